// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode/funct constants and ALU op enum
// shared by risc_v_cpu and riscv_alu
package riscv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_op_e f3_alu(input logic [2:0] f3,
                                     input logic alt);
    alu_op_e op;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational 32-bit ALU
// shifts use the low 5 bits of b_i
import riscv_pkg::*;

module riscv_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] y_o
);

  // one result per operation, wrap-around arithmetic
  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << b_i[4:0];
      ALU_SLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {31'b0, a_i < b_i};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> b_i[4:0];
      ALU_SRA:  y_o = 32'($signed(a_i) >>> b_i[4:0]);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_cpu.sv
// risc_v_cpu: byte-serial RV32I ALU subset, one instr per 4 clocks
// RISCV_LOAD_STORE_EN adds LW/SW and a 32-word data memory
import riscv_pkg::*;

module risc_v_cpu (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic [7:0] instr_i,
  input  logic       DataOrReg,
  input  logic [4:0] address,
  input  logic [1:0] vout_addr,
  output logic [7:0] value_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] hold_q, hold_d;
  logic [31:0] rf_q [32];

  logic [31:0] instr, rs1_v, rs2_v, imm_i;
  logic [31:0] op_b, alu_y, wb_data, rd_word;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        exec, wr_en;
  alu_op_e     alu_op;

`ifdef RISCV_LOAD_STORE_EN
  logic [31:0] dm_q [32];
  logic [4:0]  dm_idx;
  logic        is_load, is_store;
`endif

  // byte position and big-endian shift of the first 3 bytes
  always_comb begin
    cnt_d  = cnt_q + 2'd1;
    hold_d = {hold_q[15:0], instr_i};
  end

  // byte assembly state
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign exec  = (cnt_q == 2'd3);
  assign instr = {hold_q, instr_i};
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign rs1_v = rf_q[rs1];
  assign rs2_v = rf_q[rs2];

  // decode: ALU op, operand b, write enable
  always_comb begin
    alu_op = ALU_ADD;
    op_b   = rs2_v;
    wr_en  = 1'b0;
`ifdef RISCV_LOAD_STORE_EN
    is_load  = 1'b0;
    is_store = 1'b0;
`endif
    unique case (opc)
      OPC_OP: begin
        alu_op = f3_alu(f3, f7 == F7_ALT);
        wr_en  = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) &&
                  (f3 == F3_ADD || f3 == F3_SR));
      end
      OPC_OPIMM: begin
        op_b   = imm_i;
        alu_op = f3_alu(f3, (f3 == F3_SR) && instr[30]);
        wr_en  = 1'b1;
      end
`ifdef RISCV_LOAD_STORE_EN
      OPC_LOAD: begin
        is_load = (f3 == F3_W);
        wr_en   = (f3 == F3_W);
      end
      OPC_STORE: is_store = (f3 == F3_W);
`endif
      default: ;
    endcase
  end

  riscv_alu u_alu (
    .a_i  (rs1_v),
    .b_i  (op_b),
    .op_i (alu_op),
    .y_o  (alu_y)
  );

`ifdef RISCV_LOAD_STORE_EN
  // word index only needs the low 7 bits of rs1 + imm
  always_comb begin
    if (is_store)
      dm_idx = 5'((rs1_v[6:0] +
                   {instr[26:25], instr[11:7]}) >> 2);
    else
      dm_idx = 5'((rs1_v[6:0] + instr[26:20]) >> 2);
  end

  assign wb_data = is_load ? dm_q[dm_idx] : alu_y;

  // data memory: cleared on reset, SW writes on executing edge
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      for (int i = 0; i < 32; i++) dm_q[i] <= '0;
    end else if (exec && is_store) begin
      dm_q[dm_idx] <= rs2_v;
    end
  end
`else
  assign wb_data = alu_y;
`endif

  // register file: x0 is never written so it stays zero
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (exec && wr_en && rd != 5'd0) begin
      rf_q[rd] <= wb_data;
    end
  end

  // readout mux: pick word, then byte
  always_comb begin
`ifdef RISCV_LOAD_STORE_EN
    rd_word = DataOrReg ? rf_q[address] : dm_q[address];
`else
    rd_word = DataOrReg ? rf_q[address] : 32'd0;
`endif
    value_o = rd_word[{vout_addr, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_risc_v_cpu.sv
// tb_risc_v_cpu: directed + random byte stream vs array model
// reads happen within one 1us clock period, 1ns apart
`timescale 1ns/1ps

module tb_risc_v_cpu;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic [7:0] instr_i;
  logic       DataOrReg;
  logic [4:0] address;
  logic [1:0] vout_addr;
  logic [7:0] value_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mreg [32];
  logic [31:0] mdm  [32];
  logic [7:0]  mh   [3];
  int          mcnt;

  risc_v_cpu dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .instr_i   (instr_i),
    .DataOrReg (DataOrReg),
    .address   (address),
    .vout_addr (vout_addr),
    .value_o   (value_o)
  );

  always #500 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_ins(logic [11:0] imm,
      logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] r_ins(logic [6:0] f7,
      logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3,
      logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mdm[i]  = '0;
    end
    mcnt = 0;
  endtask

  // architectural effect of one 32-bit instruction
  task automatic m_exec(input logic [31:0] w);
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, ii, si, r, ea;
    logic        ok;
    opc = w[6:0];   rd = w[11:7]; f3 = w[14:12];
    rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
    a  = mreg[rs1]; b = mreg[rs2];
    ii = {{20{w[31]}}, w[31:20]};
    si = {{20{w[31]}}, w[31:25], w[11:7]};
    ok = 1'b0; r = '0;
    if (opc == 7'h33) begin
      ok = 1'b1;
      case ({f7, f3})
        {7'h00, 3'd0}: r = a + b;
        {7'h20, 3'd0}: r = a - b;
        {7'h00, 3'd1}: r = a << b[4:0];
        {7'h00, 3'd2}: r = ($signed(a) < $signed(b)) ? 1 : 0;
        {7'h00, 3'd3}: r = (a < b) ? 1 : 0;
        {7'h00, 3'd4}: r = a ^ b;
        {7'h00, 3'd5}: r = a >> b[4:0];
        {7'h20, 3'd5}: r = $signed(a) >>> b[4:0];
        {7'h00, 3'd6}: r = a | b;
        {7'h00, 3'd7}: r = a & b;
        default: ok = 1'b0;
      endcase
    end else if (opc == 7'h13) begin
      ok = 1'b1;
      case (f3)
        3'd0: r = a + ii;
        3'd1: r = a << ii[4:0];
        3'd2: r = ($signed(a) < $signed(ii)) ? 1 : 0;
        3'd3: r = (a < ii) ? 1 : 0;
        3'd4: r = a ^ ii;
        3'd5: r = ii[10] ? $signed(a) >>> ii[4:0]
                         : a >> ii[4:0];
        3'd6: r = a | ii;
        default: r = a & ii;
      endcase
    end
`ifdef RISCV_LOAD_STORE_EN
    else if (opc == 7'h03 && f3 == 3'd2) begin
      ea = a + ii;
      r  = mdm[ea[6:2]];
      ok = 1'b1;
    end else if (opc == 7'h23 && f3 == 3'd2) begin
      ea = a + si;
      mdm[ea[6:2]] = b;
    end
`endif
    if (ok && rd != 0) mreg[rd] = r;
  endtask

  task automatic send_byte(input logic [7:0] b);
    instr_i = b;
    @(posedge sys_clk);
    #1;
    if (mcnt == 3) m_exec({mh[0], mh[1], mh[2], b});
    else mh[mcnt] = b;
    mcnt = (mcnt + 1) % 4;
  endtask

  task automatic send_ins(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    instr_i = 8'($urandom);
    @(posedge sys_clk);
    #1;
    sys_reset = 1'b0;
    m_reset();
  endtask

  function automatic logic [7:0] m_byte(logic dor,
      logic [4:0] a, logic [1:0] s);
    logic [31:0] w;
`ifdef RISCV_LOAD_STORE_EN
    w = dor ? mreg[a] : mdm[a];
`else
    w = dor ? mreg[a] : 32'd0;
`endif
    return w[s*8 +: 8];
  endfunction

  task automatic rd_lit(input string tag, input logic dor,
      input logic [4:0] a, input logic [1:0] s,
      input logic [7:0] exp);
    DataOrReg = dor; address = a; vout_addr = s;
    #1;
    chk(tag, value_o, exp);
  endtask

  task automatic rd_mdl(input logic dor, input logic [4:0] a,
                        input logic [1:0] s);
    DataOrReg = dor; address = a; vout_addr = s;
    #1;
    chk($sformatf("model d%0d a%0d b%0d", dor, a, s),
        value_o, m_byte(dor, a, s));
  endtask

  task automatic sweep_lit0();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++)
        for (int s = 0; s < 4; s++)
          rd_lit($sformatf("reset d%0d a%0d b%0d", d, a, s),
                 1'(d), 5'(a), 2'(s), 8'h00);
  endtask

  task automatic sweep_mdl();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++)
        for (int s = 0; s < 4; s++)
          rd_mdl(1'(d), 5'(a), 2'(s));
  endtask

  function automatic logic [31:0] rand_ins();
    int k;
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    logic [6:0] f7;
    k   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    if (k == 0) f7 = 7'($urandom);
    else f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (k < 5) return i_ins(imm, rs1, 3'($urandom), rd);
    if (k < 8) return r_ins(f7, rs2, rs1, 3'($urandom), rd);
    if (k == 8) begin
      imm = 12'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1)
        return {imm, rs1, 3'd2, rd, 7'h03};
      return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    end
    return $urandom;
  endfunction

  initial begin
    sys_reset = 1'b1;
    instr_i = 8'h00;
    DataOrReg = 1'b1; address = '0; vout_addr = '0;
    m_reset();
    do_reset();
    do_reset();
    sweep_lit0();

    send_byte(8'h00); send_byte(8'h50);
    send_byte(8'h02); send_byte(8'h93);
    rd_lit("addi x5 b0", 1, 5, 0, 8'h05);
    rd_lit("addi x5 b1", 1, 5, 1, 8'h00);
    rd_lit("addi x5 b2", 1, 5, 2, 8'h00);
    rd_lit("addi x5 b3", 1, 5, 3, 8'h00);

    send_ins(32'hFFF00093);
    send_ins(32'h0040D113);
    send_ins(32'h4040D193);
    rd_lit("srli x2 b3", 1, 2, 3, 8'h0F);
    rd_lit("srli x2 b2", 1, 2, 2, 8'hFF);
    rd_lit("srli x2 b1", 1, 2, 1, 8'hFF);
    rd_lit("srli x2 b0", 1, 2, 0, 8'hFF);
    for (int s = 3; s >= 0; s--)
      rd_lit($sformatf("srai x3 b%0d", s), 1, 3, 2'(s), 8'hFF);

    send_ins(i_ins(12'd7, 0, 3'd0, 1));
    send_ins(i_ins(12'd9, 0, 3'd0, 2));
    send_ins(32'h402081B3);
    send_ins(r_ins(7'h00, 1, 2, 3'd3, 4));
    rd_lit("sub x3 b0", 1, 3, 0, 8'hFE);
    rd_lit("sub x3 b1", 1, 3, 1, 8'hFF);
    rd_lit("sub x3 b3", 1, 3, 3, 8'hFF);
    rd_lit("sltu x4 b0", 1, 4, 0, 8'h00);

    send_ins(i_ins(12'd5, 0, 3'd0, 0));
    send_ins(32'h0);
    for (int s = 0; s < 4; s++)
      rd_lit($sformatf("x0 b%0d", s), 1, 0, 2'(s), 8'h00);
    rd_lit("nop x5 kept", 1, 5, 0, 8'h05);
    rd_lit("nop x1 kept", 1, 1, 0, 8'h07);
    sweep_mdl();

    send_byte(8'hFF); send_byte(8'hF0);
    do_reset();
    send_ins(i_ins(12'd3, 0, 3'd0, 5));
    rd_lit("rst x5 b0", 1, 5, 0, 8'h03);
    rd_lit("rst x5 b1", 1, 5, 1, 8'h00);
    rd_lit("rst x3 b0", 1, 3, 0, 8'h00);
    rd_lit("rst x1 b0", 1, 1, 0, 8'h00);

    send_ins(i_ins(12'h055, 0, 3'd0, 1));
    send_ins({7'd0, 5'd1, 5'd0, 3'd2, 5'd8, 7'h23});
    send_ins({12'd8, 5'd0, 3'd2, 5'd6, 7'h03});
`ifdef RISCV_LOAD_STORE_EN
    rd_lit("sw dmem2 b0", 0, 2, 0, 8'h55);
    rd_lit("lw x6 b0", 1, 6, 0, 8'h55);
`else
    rd_lit("no dmem2 b0", 0, 2, 0, 8'h00);
    rd_lit("no lw x6 b0", 1, 6, 0, 8'h00);
`endif
    rd_lit("ls x1 b0", 1, 1, 0, 8'h55);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int j = $urandom_range(1, 3); j > 0; j--)
          send_byte(8'($urandom));
        do_reset();
      end
      send_ins(rand_ins());
      for (int j = 0; j < 3; j++)
        rd_mdl(1'($urandom), 5'($urandom), 2'($urandom));
    end
    sweep_mdl();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/risc_v_cpu.md
RISC_V_CPU -- requirements
Module: risc_v_cpu

Interface
REQ-001 The module SHALL have input `sys_clk`, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have input `sys_reset`, 1 bit: reset, synchronous, active-high.
REQ-003 The module SHALL have input `instr_i`, 8 bits: instruction byte stream, one byte consumed every clock.
REQ-004 The module SHALL have input `DataOrReg`, 1 bit: readout source select; 1 selects the register file, 0 selects data memory.
REQ-005 The module SHALL have input `address`, 5 bits: readout index; register x0..x31, or data-memory word 0..31.
REQ-006 The module SHALL have input `vout_addr`, 2 bits: byte select of the 32-bit readout word; 0 = bits 7:0, 3 = bits 31:24.
REQ-007 The module SHALL have output `value_o`, 8 bits: selected byte, combinational.

Function
REQ-008 The module SHALL assemble instructions big-endian from 4 consecutive bytes: the first byte after reset is bits 31:24 and the fourth is bits 7:0.
REQ-009 A 2-bit byte counter SHALL track position, wrap 3->0, and advance every non-reset clock.
REQ-010 At the edge where counter==3, the instruction {held 24 bits, instr_i} SHALL execute and its write-back SHALL complete at that same edge.
- Result is visible on value_o immediately after that edge.
REQ-011 Supported R-type (opcode 0110011) instructions SHALL be ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, decoded per RV32I funct3/funct7.
REQ-012 Supported I-type ALU (opcode 0010011) instructions SHALL be ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- 12-bit immediate is sign-extended.
- Shift amount is imm[4:0].
- SRAI is selected by imm[10].
REQ-013 Arithmetic SHALL be 32-bit wrap-around, and shifts SHALL use the low 5 bits of the operand.
REQ-014 SLT/SLTI SHALL compare signed and SLTU/SLTIU SHALL compare unsigned, each writing 1 or 0.
REQ-015 Register x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-016 Any other opcode, including 0x00000000, SHALL execute as a NOP with no state change.
REQ-017 There SHALL be no branches, no PC and no hazards: instructions execute strictly in stream order.
REQ-018 value_o SHALL equal byte vout_addr of reg[address] when DataOrReg=1, or of dmem[address] when DataOrReg=0.

Reset
REQ-019 When sys_reset=1 at a clock edge, the byte counter SHALL be cleared, the held instruction bytes SHALL be cleared, all 32 registers SHALL be cleared, and all 32 data-memory words SHALL be cleared.
- The byte on instr_i during a reset cycle SHALL be discarded.
REQ-020 Reset asserted mid-instruction SHALL abandon the partial instruction, and the next byte after reset deassertion SHALL be byte 0.
REQ-021 After reset, value_o SHALL be 0x00 for every select combination.

Configuration
REQ-022 With macro `RISCV_LOAD_STORE_EN` defined, the module SHALL support LW (opcode 0000011) and SW (opcode 0100011) on a 32-word data memory.
- Word index = (rs1 + sign-extended imm)[6:2].
- LW write-back follows the same timing as ALU ops.
- SW writes at the executing edge.
REQ-023 Without `RISCV_LOAD_STORE_EN`, LW and SW SHALL be NOPs, no data memory SHALL exist, and value_o SHALL be 0x00 whenever DataOrReg=0.

Structure
REQ-024 A shared package `riscv_pkg` SHALL hold the opcode, funct3 and funct7 constants and the ALU-operation enum typedef.
REQ-025 A combinational sub-module `riscv_alu` SHALL take two 32-bit operands and the ALU-op enum and produce a 32-bit result.
- Decode, byte assembly, register file, data memory and readout mux SHALL reside in the top module.

Verification
REQ-026 The bench SHALL cover: reset, then bytes 00 50 02 93 (ADDI x5,x0,5) -> DataOrReg=1, address=5 gives value_o 0x05 at vout_addr 0 and 0x00 at vout_addr 1..3.
REQ-027 The bench SHALL cover: ADDI x1,x0,-1 (FFF00093), then SRLI x2,x1,4 (0040D113), then SRAI x3,x1,4 (4040D193) -> x2=0x0FFFFFFF, x3=0xFFFFFFFF, readable byte-by-byte with vout_addr 3..0.
REQ-028 The bench SHALL cover: ADDI x1,x0,7 and ADDI x2,x0,9, then SUB x3,x1,x2 (402081B3) -> x3=0xFFFFFFFE; SLTU x4,x2,x1 -> x4=0.
REQ-029 The bench SHALL cover: ADDI x0,x0,5 followed by four 0x00 bytes -> x0 reads 0x00 and no register changes.
REQ-030 The bench SHALL cover: two bytes of an instruction, then sys_reset for 1 cycle, then a full ADDI x5,x0,3 -> x5=0x03, with no corruption from the partial bytes.
REQ-031 With `RISCV_LOAD_STORE_EN` defined, the bench SHALL cover: ADDI x1,x0,0x55, SW x1,8(x0), LW x6,8(x0) -> DataOrReg=0, address=2 gives 0x55, and x6=0x55.
